// File: rtl/led_strobe_seq.sv
// Multi-group LED strobe sequencer: splits the LED bus into equal groups and
// flashes them in alternate, all-together or ping-pong order with an optional dark gap.
module led_strobe_seq #(
  parameter int LED_W      = 8,
  parameter int GROUPS     = 2,
  parameter int TOGGLE_DIV = 200,
  parameter int FLASHES    = 6,
  parameter int GAP        = 0,
  localparam int GRP_W     = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led_out,
  output logic [GRP_W-1:0] grp,
  output logic             cycle_done
);

  localparam int GW   = LED_W / GROUPS;
  localparam int PH_W = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;
  localparam int FL_W = (FLASHES > 1) ? $clog2(FLASHES) : 1;
  localparam int GP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(TOGGLE_DIV - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASHES - 1);
  localparam logic [GP_W-1:0]  GP_LAST  = GP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(GROUPS - 1);
  localparam logic [GRP_W-1:0] GRP_ONE  = GRP_W'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FLASH = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [1:0] M_ALT  = 2'd0;
  localparam logic [1:0] M_ALL  = 2'd1;
  localparam logic [1:0] M_PP   = 2'd2;
  localparam logic [1:0] M_DARK = 2'd3;

  // With two or fewer groups ping-pong degenerates into plain alternation.
  localparam bit PP_REAL = (GROUPS > 2);

  logic [1:0]       state_q, state_d;
  logic [PH_W-1:0]  phase_cnt_q, phase_cnt_d;
  logic [FL_W-1:0]  flash_cnt_q, flash_cnt_d;
  logic [GP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic             phase_on_q, phase_on_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic [GRP_W-1:0] grp_q, grp_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             done_q, done_d;

  logic [GRP_W-1:0] adv_grp;
  logic             adv_dir;
  logic             adv_wrap;
  logic             slot_end;

  function automatic logic [LED_W-1:0] slot_mask(input logic [GRP_W-1:0] g,
                                                 input logic [1:0]       m);
    logic [LED_W-1:0] base;
    base         = '0;
    base[GW-1:0] = '1;
    if (m == M_ALL) slot_mask = '1;
    else            slot_mask = base << (int'(g) * GW);
  endfunction

  // Group and direction the next slot would use, and whether it closes the sequence.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    adv_grp  = '0;
    adv_dir  = 1'b0;
    adv_wrap = 1'b0;
    if (mode_q == M_PP && PP_REAL) begin
      if (!dir_q) begin
        if (grp_q == GRP_LAST) begin
          adv_grp = grp_q - GRP_ONE;
          adv_dir = 1'b1;
        end else begin
          adv_grp = grp_q + GRP_ONE;
        end
      end else if (grp_q == GRP_ONE) begin
        adv_wrap = 1'b1;
      end else begin
        adv_grp = grp_q - GRP_ONE;
        adv_dir = 1'b1;
      end
    end else if (mode_q == M_ALL || grp_q == GRP_LAST) begin
      adv_wrap = 1'b1;
    end else begin
      adv_grp = grp_q + GRP_ONE;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    flash_cnt_d = flash_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    phase_on_d  = phase_on_q;
    dir_d       = dir_q;
    mode_d      = mode_q;
    grp_d       = grp_q;
    led_d       = led_q;
    done_d      = 1'b0;
    slot_end    = 1'b0;

    if (!en) begin
      state_d     = S_IDLE;
      phase_cnt_d = '0;
      flash_cnt_d = '0;
      gap_cnt_d   = '0;
      phase_on_d  = 1'b0;
      dir_d       = 1'b0;
      grp_d       = '0;
      led_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          led_d = '0;
          if (mode != M_DARK) begin
            state_d     = S_FLASH;
            mode_d      = mode;
            grp_d       = '0;
            dir_d       = 1'b0;
            phase_cnt_d = '0;
            flash_cnt_d = '0;
            gap_cnt_d   = '0;
            phase_on_d  = 1'b1;
            led_d       = slot_mask('0, mode);
          end
        end
        S_FLASH: begin
          if (phase_cnt_q == PH_LAST) begin
            phase_cnt_d = '0;
            if (phase_on_q) begin
              phase_on_d = 1'b0;
              led_d      = '0;
            end else if (flash_cnt_q != FL_LAST) begin
              flash_cnt_d = flash_cnt_q + FL_W'(1);
              phase_on_d  = 1'b1;
              led_d       = slot_mask(grp_q, mode_q);
            end else if (GAP > 0) begin
              state_d     = S_GAP;
              flash_cnt_d = '0;
              gap_cnt_d   = '0;
              led_d       = '0;
            end else begin
              slot_end = 1'b1;
            end
          end else begin
            phase_cnt_d = phase_cnt_q + PH_W'(1);
          end
        end
        S_GAP: begin
          led_d = '0;
          if (gap_cnt_q == GP_LAST) slot_end = 1'b1;
          else                      gap_cnt_d = gap_cnt_q + GP_W'(1);
        end
        default: begin
          state_d = S_IDLE;
          led_d   = '0;
          grp_d   = '0;
        end
      endcase

      if (slot_end) begin
        phase_cnt_d = '0;
        flash_cnt_d = '0;
        gap_cnt_d   = '0;
        if (adv_wrap) begin
          // The wrap is the only point besides the IDLE exit where mode is re-sampled.
          done_d = 1'b1;
          mode_d = mode;
          grp_d  = '0;
          dir_d  = 1'b0;
          if (mode == M_DARK) begin
            state_d    = S_IDLE;
            phase_on_d = 1'b0;
            led_d      = '0;
          end else begin
            state_d    = S_FLASH;
            phase_on_d = 1'b1;
            led_d      = slot_mask('0, mode);
          end
        end else begin
          state_d    = S_FLASH;
          grp_d      = adv_grp;
          dir_d      = adv_dir;
          phase_on_d = 1'b1;
          led_d      = slot_mask(adv_grp, mode_q);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= S_IDLE;
      phase_cnt_q <= '0;
      flash_cnt_q <= '0;
      gap_cnt_q   <= '0;
      phase_on_q  <= 1'b0;
      dir_q       <= 1'b0;
      mode_q      <= M_ALT;
      grp_q       <= '0;
      led_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      flash_cnt_q <= flash_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      phase_on_q  <= phase_on_d;
      dir_q       <= dir_d;
      mode_q      <= mode_d;
      grp_q       <= grp_d;
      led_q       <= led_d;
      done_q      <= done_d;
    end
  end

  assign led_out    = led_q;
  assign grp        = grp_q;
  assign cycle_done = done_q;

endmodule
